// File: rtl/memory_access_controller.sv
// memory_access_controller
//
// Turns level load/store strobes from the load/store unit into one or two
// byte-wide beats on an external memory bus. Halfword accesses run as two
// little-endian beats (A, then A+1 with 16-bit wrap). The controller answers
// with a one-cycle reset_memory_access pulse. A beat that waits too long for
// mem_ready is abandoned; error then stays set until reset.
//
// Ports
//   clock                         system clock, rising edge
//   reset                         asynchronous, active-low
//   memory_access_load_byte       load byte request (highest priority)
//   memory_access_load_halfword   load halfword request
//   memory_access_store_byte      store byte request
//   memory_access_store_halfword  store halfword request (lowest priority)
//   target_address[15:0]          access byte address, latched at start
//   target_data[15:0]             store data, latched at start
//   reset_memory_access           one-cycle completion pulse (DONE)
//   memory_data[15:0]             registered load result
//   mem_request                   bus request, high in BEAT0/BEAT1
//   mem_write                     bus write qualifier (stores only)
//   mem_address[15:0]             bus byte address
//   mem_write_data[7:0]           bus write byte
//   mem_ready                     bus beat accept/complete
//   mem_read_data[7:0]            bus read byte, sampled on completion
//   busy                          controller not IDLE
//   error                         sticky timeout flag
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a strobe; latches op, address and data
// BEAT0 | bus beat at A, byte [7:0]
// BEAT1 | bus beat at A+1, byte [15:8] (halfword ops only)
// DONE  | completion pulse for one cycle, then back to IDLE

module memory_access_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_access_load_byte,
    input  logic        memory_access_load_halfword,
    input  logic        memory_access_store_byte,
    input  logic        memory_access_store_halfword,
    input  logic [15:0] target_address,
    input  logic [15:0] target_data,
    output logic        reset_memory_access,
    output logic [15:0] memory_data,
    output logic        mem_request,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_write_data,
    input  logic        mem_ready,
    input  logic [7:0]  mem_read_data,
    output logic        busy,
    output logic        error
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
    typedef enum logic [1:0] {OP_LB, OP_LH, OP_SB, OP_SH} op_t;

    // A beat gives up when its wait counter would reach this value.
    localparam logic [7:0] WAIT_LAST = 8'd254;

    state_t      state_q, state_d;
    op_t         op_q, op_sel;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic [7:0]  byte0_q;
    logic [7:0]  wait_cnt_q;
    logic        any_strobe;
    logic        is_halfword;
    logic        is_store;
    logic        beat_done;
    logic        timeout;

    assign any_strobe  = memory_access_load_byte | memory_access_load_halfword |
                         memory_access_store_byte | memory_access_store_halfword;
    assign is_halfword = (op_q == OP_LH) || (op_q == OP_SH);
    assign is_store    = (op_q == OP_SB) || (op_q == OP_SH);

    always_comb begin
        op_sel = OP_SH;
        if (memory_access_load_byte)
            op_sel = OP_LB;
        else if (memory_access_load_halfword)
            op_sel = OP_LH;
        else if (memory_access_store_byte)
            op_sel = OP_SB;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d             = state_q;
        mem_request         = 1'b0;
        mem_write           = 1'b0;
        mem_address         = 16'h0000;
        mem_write_data      = 8'h00;
        reset_memory_access = 1'b0;
        busy                = 1'b1;
        beat_done           = 1'b0;
        timeout             = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (any_strobe)
                    state_d = BEAT0;
            end
            BEAT0: begin
                mem_request    = 1'b1;
                mem_write      = is_store;
                mem_address    = addr_q;
                mem_write_data = data_q[7:0];
                beat_done      = mem_ready;
                // A ready on the last allowed wait cycle still completes.
                timeout        = !mem_ready && (wait_cnt_q == WAIT_LAST);
                if (beat_done)
                    state_d = is_halfword ? BEAT1 : DONE;
                else if (timeout)
                    state_d = DONE;
            end
            BEAT1: begin
                mem_request    = 1'b1;
                mem_write      = is_store;
                mem_address    = addr_q + 16'd1;
                mem_write_data = data_q[15:8];
                beat_done      = mem_ready;
                timeout        = !mem_ready && (wait_cnt_q == WAIT_LAST);
                if (beat_done || timeout)
                    state_d = DONE;
            end
            DONE: begin
                reset_memory_access = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q        <= OP_LB;
            addr_q      <= 16'h0000;
            data_q      <= 16'h0000;
            byte0_q     <= 8'h00;
            wait_cnt_q  <= 8'h00;
            memory_data <= 16'h0000;
            error       <= 1'b0;
        end else begin
            if ((state_q == IDLE) && any_strobe) begin
                op_q   <= op_sel;
                addr_q <= target_address;
                data_q <= target_data;
            end

            // Counting only while staying in the same beat clears the counter
            // automatically whenever a new beat begins.
            if (mem_request && !mem_ready && (state_d == state_q))
                wait_cnt_q <= wait_cnt_q + 8'd1;
            else
                wait_cnt_q <= 8'h00;

            // The low byte of a halfword load is parked until the high byte
            // arrives so a BEAT1 timeout leaves memory_data untouched.
            if ((state_q == BEAT0) && beat_done) begin
                byte0_q <= mem_read_data;
                if (op_q == OP_LB)
                    memory_data <= {8'h00, mem_read_data};
            end
            if ((state_q == BEAT1) && beat_done && (op_q == OP_LH))
                memory_data <= {mem_read_data, byte0_q};

            if (timeout)
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_memory_access_controller.sv
module tb_memory_access_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        lb, lh, sb, sh;
    logic [15:0] target_address, target_data;
    logic        reset_memory_access;
    logic [15:0] memory_data;
    logic        mem_request, mem_write;
    logic [15:0] mem_address;
    logic [7:0]  mem_write_data;
    logic        mem_ready;
    logic [7:0]  mem_read_data;
    logic        busy, error;

    always #5 clock = ~clock;

    memory_access_controller dut (
        .clock                        (clock),
        .reset                        (reset),
        .memory_access_load_byte      (lb),
        .memory_access_load_halfword  (lh),
        .memory_access_store_byte     (sb),
        .memory_access_store_halfword (sh),
        .target_address               (target_address),
        .target_data                  (target_data),
        .reset_memory_access          (reset_memory_access),
        .memory_data                  (memory_data),
        .mem_request                  (mem_request),
        .mem_write                    (mem_write),
        .mem_address                  (mem_address),
        .mem_write_data               (mem_write_data),
        .mem_ready                    (mem_ready),
        .mem_read_data                (mem_read_data),
        .busy                         (busy),
        .error                        (error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: last completed load result and sticky error flag.
    logic [15:0] mdl_mem_data = 16'h0000;
    bit          mdl_error    = 1'b0;

    // strobes: [0]=load_byte [1]=load_halfword [2]=store_byte [3]=store_halfword
    // lat0/lat1: wait cycles before mem_ready for each beat; 255 means never.
    typedef struct {
        logic [3:0]  strobes;
        logic [15:0] addr;
        logic [15:0] data;
        int          lat0;
        int          lat1;
        logic [7:0]  rd0;
        logic [7:0]  rd1;
        int          exp_beats;
        logic [15:0] exp_addr0;
        logic [15:0] exp_addr1;
        logic        exp_write;
        logic [7:0]  exp_wd0;
        logic [7:0]  exp_wd1;
        logic [15:0] exp_mem_data;
        logic        exp_timeout;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " pulse"}, 64'(reset_memory_access), 64'd0);
        chk({tag, " memory_data"}, 64'(memory_data), 64'd0);
        chk({tag, " mem_request"}, 64'(mem_request), 64'd0);
        chk({tag, " mem_write"}, 64'(mem_write), 64'd0);
        chk({tag, " mem_address"}, 64'(mem_address), 64'd0);
        chk({tag, " mem_write_data"}, 64'(mem_write_data), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " error"}, 64'(error), 64'd0);
    endtask

    // Behavioural prediction straight from the access rules.
    function automatic vec_t predict(input vec_t s);
        vec_t r = s;
        bit load, half, to0, to1;
        load = s.strobes[0] || s.strobes[1];
        half = s.strobes[0] ? 1'b0 : s.strobes[1] ? 1'b1 : s.strobes[2] ? 1'b0 : 1'b1;
        to0  = (s.lat0 >= 255);
        to1  = half && !to0 && (s.lat1 >= 255);
        r.exp_timeout  = to0 || to1;
        r.exp_beats    = (half && !to0) ? 2 : 1;
        r.exp_addr0    = s.addr;
        r.exp_addr1    = 16'((32'(s.addr) + 1) % 65536);
        r.exp_write    = !load;
        r.exp_wd0      = s.data[7:0];
        r.exp_wd1      = s.data[15:8];
        r.exp_mem_data = mdl_mem_data;
        if (load && !r.exp_timeout)
            r.exp_mem_data = half ? {s.rd1, s.rd0} : {8'h00, s.rd0};
        return r;
    endfunction

    // Runs one access as the load/store unit plus a bus responder would.
    task automatic do_access(input string tag, input vec_t v);
        int cyc = 0, beat = 0, seen = 0, waited = 0, pulses = 0, stab_err = 0, lat;
        bit in_beat = 0, after_pulse = 0, finished = 0;
        logic [15:0] a_first;
        logic        w_first;
        logic [7:0]  d_first;
        bit exp_err;
        exp_err = mdl_error || v.exp_timeout;

        @(negedge clock);
        {sh, sb, lh, lb} = v.strobes;
        target_address = v.addr;
        target_data    = v.data;
        mem_ready      = 1'b0;

        while (!finished && cyc < 1000) begin
            @(negedge clock);
            cyc++;
            // The access is latched by now; later changes must be ignored.
            if (cyc == 1) begin
                target_address = 16'($urandom);
                target_data    = 16'($urandom);
            end
            mem_ready = 1'b0;
            if (after_pulse) begin
                chk({tag, " idle busy"}, 64'(busy), 64'd0);
                chk({tag, " single pulse"}, 64'(reset_memory_access), 64'd0);
                chk({tag, " held memory_data"}, 64'(memory_data), 64'(v.exp_mem_data));
                finished = 1;
            end else if (reset_memory_access) begin
                pulses++;
                after_pulse = 1;
                {sh, sb, lh, lb} = 4'b0000;
                chk({tag, " memory_data"}, 64'(memory_data), 64'(v.exp_mem_data));
                chk({tag, " done busy"}, 64'(busy), 64'd1);
                chk({tag, " error"}, 64'(error), 64'(exp_err));
                chk({tag, " request in done"}, 64'(mem_request), 64'd0);
                if (v.exp_timeout)
                    chk({tag, " wait cycles before abort"}, 64'(waited), 64'd255);
            end else if (mem_request) begin
                if (!in_beat) begin
                    in_beat = 1;
                    seen++;
                    waited  = 0;
                    a_first = mem_address;
                    w_first = mem_write;
                    d_first = mem_write_data;
                    chk({tag, " beat addr"}, 64'(mem_address),
                        64'((beat == 0) ? v.exp_addr0 : v.exp_addr1));
                    chk({tag, " beat write"}, 64'(mem_write), 64'(v.exp_write));
                    if (v.exp_write)
                        chk({tag, " beat wdata"}, 64'(mem_write_data),
                            64'((beat == 0) ? v.exp_wd0 : v.exp_wd1));
                end else if (mem_address !== a_first || mem_write !== w_first ||
                             mem_write_data !== d_first) begin
                    stab_err++;
                end
                lat = (beat == 0) ? v.lat0 : v.lat1;
                if (waited == lat) begin
                    mem_ready     = 1'b1;
                    mem_read_data = (beat == 0) ? v.rd0 : v.rd1;
                    beat++;
                    in_beat = 0;
                end else begin
                    waited++;
                    mem_read_data = 8'($urandom);
                end
            end
        end
        mem_ready = 1'b0;
        {sh, sb, lh, lb} = 4'b0000;
        chk({tag, " completed in budget"}, 64'(finished), 64'd1);
        chk({tag, " pulse count"}, 64'(pulses), 64'd1);
        chk({tag, " beats seen"}, 64'(seen), 64'(v.exp_beats));
        chk({tag, " bus stable while waiting"}, 64'(stab_err), 64'd0);
        mdl_mem_data = v.exp_mem_data;
        mdl_error    = exp_err;
    endtask

    vec_t tbl[9];
    vec_t rv;

    initial begin
        // strobes, addr, data, lat0, lat1, rd0, rd1,
        // beats, addr0, addr1, write, wd0, wd1, mem_data, timeout
        tbl[0] = '{4'b0001, 16'h1234, 16'h0000, 1, 0, 8'hAB, 8'h00,
                   1, 16'h1234, 16'h1235, 1'b0, 8'h00, 8'h00, 16'h00AB, 1'b0};
        tbl[1] = '{4'b0010, 16'hFFFF, 16'h0000, 0, 0, 8'h34, 8'h12,
                   2, 16'hFFFF, 16'h0000, 1'b0, 8'h00, 8'h00, 16'h1234, 1'b0};
        tbl[2] = '{4'b1000, 16'h0100, 16'hBEEF, 3, 3, 8'h00, 8'h00,
                   2, 16'h0100, 16'h0101, 1'b1, 8'hEF, 8'hBE, 16'h1234, 1'b0};
        tbl[3] = '{4'b0101, 16'h2000, 16'h0077, 0, 0, 8'hC3, 8'h00,
                   1, 16'h2000, 16'h2001, 1'b0, 8'h00, 8'h00, 16'h00C3, 1'b0};
        tbl[4] = '{4'b0100, 16'h0042, 16'h1155, 2, 0, 8'h00, 8'h00,
                   1, 16'h0042, 16'h0043, 1'b1, 8'h55, 8'h11, 16'h00C3, 1'b0};
        tbl[5] = '{4'b0010, 16'h8000, 16'h0000, 254, 0, 8'h01, 8'h80,
                   2, 16'h8000, 16'h8001, 1'b0, 8'h00, 8'h00, 16'h8001, 1'b0};
        tbl[6] = '{4'b0001, 16'h4444, 16'h0000, 255, 0, 8'hEE, 8'h00,
                   1, 16'h4444, 16'h4445, 1'b0, 8'h00, 8'h00, 16'h8001, 1'b1};
        tbl[7] = '{4'b0010, 16'h5555, 16'h0000, 0, 255, 8'h66, 8'h77,
                   2, 16'h5555, 16'h5556, 1'b0, 8'h00, 8'h00, 16'h8001, 1'b1};
        tbl[8] = '{4'b1110, 16'h0FFE, 16'hABCD, 1, 2, 8'h22, 8'h33,
                   2, 16'h0FFE, 16'h0FFF, 1'b0, 8'h00, 8'h00, 16'h3322, 1'b0};

        reset = 1'b0;
        {sh, sb, lh, lb} = 4'b0000;
        target_address = 16'h0000;
        target_data    = 16'h0000;
        mem_ready      = 1'b0;
        mem_read_data  = 8'h00;
        #1;
        chk_outputs_zero("reset");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk_outputs_zero("after reset");

        for (int i = 0; i < 9; i++)
            do_access($sformatf("vec%0d", i), tbl[i]);

        for (int i = 0; i < 40; i++) begin
            rv.strobes = 4'($urandom_range(1, 15));
            rv.addr    = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
            rv.data    = 16'($urandom);
            rv.lat0    = $urandom_range(0, 3);
            rv.lat1    = $urandom_range(0, 3);
            rv.rd0     = 8'($urandom);
            rv.rd1     = 8'($urandom);
            do_access($sformatf("rnd%0d", i), predict(rv));
        end

        // Strobe held through DONE: one idle cycle, then a second access.
        begin
            bit exp_busy[6]  = '{1, 1, 0, 1, 1, 0};
            bit exp_pulse[6] = '{0, 1, 0, 0, 1, 0};
            @(negedge clock);
            lb = 1'b1;
            target_address = 16'h0A0A;
            mem_ready      = 1'b1;
            mem_read_data  = 8'h5A;
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                chk($sformatf("held strobe busy c%0d", i), 64'(busy), 64'(exp_busy[i]));
                chk($sformatf("held strobe pulse c%0d", i), 64'(reset_memory_access),
                    64'(exp_pulse[i]));
                if (i == 3)
                    lb = 1'b0;
            end
            mem_ready = 1'b0;
            chk("held strobe memory_data", 64'(memory_data), 64'h005A);
            mdl_mem_data = 16'h005A;
        end

        // Reset in the middle of BEAT1: everything clears at once, no pulse.
        begin
            int pulses = 0;
            @(negedge clock);
            lh = 1'b1;
            target_address = 16'h3000;
            @(negedge clock);
            lh = 1'b0;
            chk("rst beat0 addr", 64'(mem_address), 64'h3000);
            mem_ready     = 1'b1;
            mem_read_data = 8'h99;
            @(negedge clock);
            mem_ready = 1'b0;
            chk("rst beat1 addr", 64'(mem_address), 64'h3001);
            chk("rst beat1 request", 64'(mem_request), 64'd1);
            #2;
            reset = 1'b0;
            #1;
            chk_outputs_zero("mid-beat1 reset");
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                if (reset_memory_access)
                    pulses++;
            end
            reset = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                if (reset_memory_access)
                    pulses++;
            end
            chk("rst no completion pulse", 64'(pulses), 64'd0);
            chk_outputs_zero("after mid-beat1 reset");
            mdl_mem_data = 16'h0000;
            mdl_error    = 1'b0;
        end

        // Controller works normally after the abandoned access.
        rv.strobes = 4'b0001;
        rv.addr    = 16'h7777;
        rv.data    = 16'h0000;
        rv.lat0    = 0;
        rv.lat1    = 0;
        rv.rd0     = 8'h42;
        rv.rd1     = 8'h00;
        do_access("post reset", predict(rv));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
